// File: rtl/pdp1_shift_pkg.sv
// Shared definitions for the PDP-1 shift/rotate sequencer: FSM states,
// target-register codes and bit positions within the instruction word
// (bit 0 is the MSB, as on the PDP-1).
package pdp1_shift_pkg;

   localparam int unsigned REG_W   = 18;
   localparam int unsigned FIELD_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_STEP = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

   localparam logic [1:0] TGT_NONE = 2'b00;
   localparam logic [1:0] TGT_AC   = 2'b01;
   localparam logic [1:0] TGT_IO   = 2'b10;
   localparam logic [1:0] TGT_ACIO = 2'b11;

   localparam int unsigned F_DIR    = 5;
   localparam int unsigned F_SHIFT  = 6;
   localparam int unsigned F_TGT_HI = 7;
   localparam int unsigned F_TGT_LO = 8;
   localparam int unsigned F_CNT_HI = 9;
   localparam int unsigned F_CNT_LO = 17;

endpackage

// File: rtl/pdp1_shift_popcnt.sv
// Converts the shift-count field into a step count: the PDP-1 shifts by the
// number of ones in the field, not by its binary value.
module pdp1_shift_popcnt
   import pdp1_shift_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic [0:CNT_W-1] field,
   output logic [3:0]       n
);

   // Count the ones in the field.
   always_comb begin
      n = 4'd0;
      for (int i = 0; i < CNT_W; i++) begin
         n = n + {3'b000, field[i]};
      end
   end

endmodule

// File: rtl/pdp1_shift_seq.sv
// Serial executor for PDP-1 shift/rotate group instructions. One bit
// position is processed per clock on AC, IO or the 36-bit AC:IO pair.
// All outputs come straight from registers.
module pdp1_shift_seq
   import pdp1_shift_pkg::*;
#(
   parameter int W     = 18,
   parameter int CNT_W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [0:W-1] instr,
   input  logic [0:W-1] ac_in,
   input  logic [0:W-1] io_in,
   output logic         busy,
   output logic         done,
   output logic         illegal,
   output logic [0:W-1] ac_out,
   output logic [0:W-1] io_out
);

   state_t         state_r, state_s;
   logic [0:W-1]   ac_r, ac_s;
   logic [0:W-1]   io_r, io_s;
   logic [3:0]     cnt_r, cnt_s;
   logic           busy_r, busy_s;
   logic           done_r, done_s;
   logic           illegal_r, illegal_s;
   logic           dir_r, dir_s;
   logic           shift_r, shift_s;
   logic [1:0]     tgt_r, tgt_s;
   logic [3:0]     n_s;
   logic [0:2*W-1] pair_s;
   logic           opcode_unused_s;

   // Opcode bits are decoded upstream; they are intentionally not used here.
   assign opcode_unused_s = ^instr[0:4];

   // One-bit step on a single 18-bit register. Shifts keep the sign; a left
   // shift refills bit 17 with the sign (ones'-complement semantics).
   function automatic logic [0:W-1] step_one(input logic [0:W-1] v,
                                             input logic right,
                                             input logic shift);
      logic [0:W-1] r;
      if (right) begin
         if (shift) r = {v[0], v[0:W-2]};
         else       r = {v[W-1], v[0:W-2]};
      end else begin
         if (shift) r = {v[0], v[2:W-1], v[0]};
         else       r = {v[1:W-1], v[0]};
      end
      return r;
   endfunction

   // Same step on the AC:IO pair treated as one 36-bit word with AC's sign.
   function automatic logic [0:2*W-1] step_pair(input logic [0:2*W-1] v,
                                                input logic right,
                                                input logic shift);
      logic [0:2*W-1] r;
      if (right) begin
         if (shift) r = {v[0], v[0:2*W-2]};
         else       r = {v[2*W-1], v[0:2*W-2]};
      end else begin
         if (shift) r = {v[0], v[2:2*W-1], v[0]};
         else       r = {v[1:2*W-1], v[0]};
      end
      return r;
   endfunction

   pdp1_shift_popcnt #(.CNT_W(CNT_W)) u_popcnt (
      .field (instr[F_CNT_HI:F_CNT_LO]),
      .n     (n_s)
   );

   // Combined step result, used only when the target is AC:IO.
   always_comb begin
      pair_s = step_pair({ac_r, io_r}, dir_r, shift_r);
   end

   // Next-state, datapath and output-register decode.
   always_comb begin
      state_s   = state_r;
      ac_s      = ac_r;
      io_s      = io_r;
      cnt_s     = cnt_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      illegal_s = 1'b0;
      dir_s     = dir_r;
      shift_s   = shift_r;
      tgt_s     = tgt_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               dir_s   = instr[F_DIR];
               shift_s = instr[F_SHIFT];
               tgt_s   = instr[F_TGT_HI:F_TGT_LO];
               ac_s    = ac_in;
               io_s    = io_in;
               cnt_s   = n_s;
               busy_s  = 1'b1;
               if ((n_s != 4'd0) && (instr[F_TGT_HI:F_TGT_LO] != TGT_NONE)) begin
                  state_s = ST_STEP;
               end else begin
                  state_s   = ST_FIN;
                  done_s    = 1'b1;
                  illegal_s = (instr[F_TGT_HI:F_TGT_LO] == TGT_NONE);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_STEP: begin
            case (tgt_r)
               TGT_AC:   ac_s = step_one(ac_r, dir_r, shift_r);
               TGT_IO:   io_s = step_one(io_r, dir_r, shift_r);
               TGT_ACIO: begin
                  ac_s = pair_s[0:W-1];
                  io_s = pair_s[W:2*W-1];
               end
               default: begin
                  ac_s = ac_r;
                  io_s = io_r;
               end
            endcase
            cnt_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               state_s = ST_FIN;
               done_s  = 1'b1;
            end else begin
               state_s = ST_STEP;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         ac_r      <= '0;
         io_r      <= '0;
         cnt_r     <= 4'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         illegal_r <= 1'b0;
         dir_r     <= 1'b0;
         shift_r   <= 1'b0;
         tgt_r     <= 2'b00;
      end else begin
         state_r   <= state_s;
         ac_r      <= ac_s;
         io_r      <= io_s;
         cnt_r     <= cnt_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         illegal_r <= illegal_s;
         dir_r     <= dir_s;
         shift_r   <= shift_s;
         tgt_r     <= tgt_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign illegal = illegal_r;
   assign ac_out  = ac_r;
   assign io_out  = io_r;

endmodule

// File: doc/pdp1_shift_seq.md
Name: pdp1_shift_seq

Overview:
- Sequencer that executes PDP-1 shift/rotate group instructions (octal 66xxxx/67xxxx) on AC, IO or combined AC:IO, one bit position per clock.
- Sits between the instruction decoder/control unit and the register file: control issues start plus the instruction word, the block iterates and returns the updated AC/IO with a done pulse.
- Complements the combinational shifter: serial, 36-bit-capable, handshaked.

Parameters:
- W, 18, register width (bit 0 = MSB/sign); only 18 supported.
- CNT_W, 9, width of the count field (instr[9:17]).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- instr  in  [0:17]  instruction word; [0:4]=opcode 33 (not checked here), [5]=dir (0 left, 1 right), [6]=1 shift / 0 rotate, [7:8]=01 AC, 10 IO, 11 AC:IO, 00 illegal; [9:17]=count field
- ac_in  in  [0:17]  AC value at start
- io_in  in  [0:17]  IO value at start
- busy  out  1  high from accept until done cycle inclusive
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; high when instr[7:8]=00
- ac_out  out  [0:17]  result AC, held until next accept
- io_out  out  [0:17]  result IO, held until next accept

Behaviour:
- Reset: state IDLE; busy=0, done=0, illegal=0, ac_out=0, io_out=0, internal count=0. Reset mid-operation aborts immediately; no done.
- Shift count N = number of ones in instr[9:17], range 0..9 (e.g. 000777 -> 9, 000007 -> 3).
- States: IDLE, STEP, FIN.
- IDLE: start=1 at edge E0 -> latch instr fields, load ac_out/io_out from ac_in/io_in, latch N; go to STEP if N>0 and target legal, else FIN. start=0 -> stay.
- STEP: each edge performs exactly one 1-bit operation, decrements count; on the edge where count goes 1->0, go to FIN.
- FIN: done=1, busy=1 for one cycle; next edge -> IDLE, done=0, busy=0. start in FIN is ignored.
- Timing: done is visible in the cycle after edge E0+N (N=0 or illegal: cycle after E0).
- start while busy is ignored; no queueing.
- Operations, one step (sign = bit 0):
  - Rotate left/right: circular over 18 bits (AC or IO) or 36 bits (AC[0:17]:IO[0:17]).
  - Shift right: sign unchanged and copied into bit 1; bit 17 is lost (combined: AC[17] -> IO[0], IO[17] lost).
  - Shift left: sign unchanged; bits 1..16 <- bits 2..17; bit 17 <- sign (ones'-complement fill). Combined: AC[17] <- IO[0], IO[0..16] <- IO[1..17], IO[17] <- AC sign.
- The untargeted register is never modified.
- Illegal target: no register change, illegal=1 with done, done timing as for N=0.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package pdp1_shift_pkg: state encoding (IDLE/STEP/FIN), target codes (TGT_AC=2'b01, TGT_IO=2'b10, TGT_ACIO=2'b11), instruction field bit positions.
- One sub-module: pdp1_shift_popcnt (9-bit count field -> 4-bit N, combinational), instantiated once.
- FSM, step datapath and output registers live in pdp1_shift_seq.

Test Plan:
- ral 1: instr=661001, AC=400000 -> after 1 step AC=000001, IO unchanged, done in the cycle after E0+1, illegal=0.
- sar 3: instr=675007, AC=400000 -> AC=740000; done after E0+3; busy high for 4 cycles.
- sal 1 ones'-complement: instr=665001, AC=777776 -> AC=777775; AC=200000 -> AC=000000.
- rcr 1: instr=673001, AC=000001, IO=000000 -> AC=000000, IO=400000. scl 9: instr=667777, AC=000000, IO=777777 -> AC=000777, IO=777000.
- Zero count / illegal: instr=661000 -> done after E0, AC unchanged. instr=660001 -> illegal=1 with done, registers unchanged.
- Robustness: start held high during a 9-step rcl -> exactly one done, no re-accept until IDLE. rst asserted at step 4 -> next cycle busy=0, done=0, outputs 0, no done pulse afterwards.
